// File: rtl/pc_redirect_ctrl_if.sv
// Bus between the PC unit and pc_redirect_ctrl: fetch inputs, irq line, decoded redirect outputs.
// master drives pc/instr/irq; slave (the controller) drives the redirect signals.
interface pc_redirect_ctrl_if;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        irq;
    logic [2:0]  PCSrc;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic        trap;
    logic [31:0] epc;
    logic        irq_pend;

    modport master (
        output pc, instr, irq,
        input  PCSrc, ConBA, JT, trap, epc, irq_pend
    );

    modport slave (
        input  pc, instr, irq,
        output PCSrc, ConBA, JT, trap, epc, irq_pend
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect control: instruction decode into PCSrc/ConBA/JT, irq/illegal-opcode traps and EPC capture.
// Optional IRQ_SYNC_EN adds a 2-flop synchroniser on irq ahead of the edge detector.
module pc_redirect_ctrl #(
    parameter int unsigned IRQ_GAP = 4
) (
    input logic               clk,
    input logic               reset,
    pc_redirect_ctrl_if.slave bus
);

    localparam logic [0:0] StRun = 1'b0;
    localparam logic [0:0] StGap = 1'b1;
    localparam logic [3:0] GapInit = 4'(IRQ_GAP);

    logic [0:0]  state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_pend_q, irq_pend_d;
    logic        irq_q;
    logic        irq_src;
    logic        irq_edge;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [2:0]  cls;
    logic        illegal;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [31:0] br_sum;
    logic        irq_mask;
    logic        take_irq;
    logic        take_ill;
    logic        kernel_ret;
    logic [2:0]  pcsrc_int;

`ifdef IRQ_SYNC_EN
    logic irq_s1_q, irq_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_s1_q <= 1'b0;
            irq_s2_q <= 1'b0;
        end else begin
            irq_s1_q <= bus.irq;
            irq_s2_q <= irq_s1_q;
        end
    end

    assign irq_src = irq_s2_q;
`else
    assign irq_src = bus.irq;
`endif

    assign irq_edge = irq_src & ~irq_q;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    always_comb begin
        cls     = 3'b000;
        illegal = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h08, 6'h09: cls = 3'b011;
                    6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: cls = 3'b000;
                    default: illegal = 1'b1;
                endcase
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: cls = 3'b001;
            6'h02, 6'h03: cls = 3'b010;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: cls = 3'b000;
            default: illegal = 1'b1;
        endcase
    end

    // Branch target keeps the current mode bit so a branch can never cross kernel/user.
    assign pc_plus4  = bus.pc + 32'd4;
    assign imm_ext   = {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
    assign br_sum    = pc_plus4 + imm_ext;
    assign bus.ConBA = {bus.pc[31], br_sum[30:0]};
    assign bus.JT    = bus.instr[25:0];

    assign irq_mask   = (state_q == StGap) | bus.pc[31];
    assign take_irq   = irq_pend_q & ~irq_mask;
    assign take_ill   = ~take_irq & illegal;
    assign kernel_ret = (state_q == StRun) & (cls == 3'b011) & bus.pc[31];

    always_comb begin
        pcsrc_int = cls;
        if (take_irq) begin
            pcsrc_int = 3'b100;
        end else if (take_ill) begin
            pcsrc_int = 3'b101;
        end
    end

    assign bus.PCSrc    = reset ? 3'b000 : pcsrc_int;
    assign bus.trap     = ~reset & (take_irq | take_ill);
    assign bus.epc      = epc_q;
    assign bus.irq_pend = irq_pend_q;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            StRun: begin
                if (kernel_ret) begin
                    state_d   = StGap;
                    gap_cnt_d = GapInit;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q <= 4'd1) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        epc_d = epc_q;
        if (take_irq) begin
            epc_d = bus.pc;
        end else if (take_ill) begin
            epc_d = pc_plus4;
        end
    end

    // A fresh edge in the same cycle as a service leaves the request pending for a second trap.
    assign irq_pend_d = irq_edge | (irq_pend_q & ~take_irq);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            gap_cnt_q  <= 4'd0;
            epc_q      <= 32'd0;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            epc_q      <= epc_d;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_src;
        end
    end

endmodule
